mult_div_unit: RTL and testbench

Parametrised multicycle multiply/divide unit for the multicycle MIPS datapath, feeding the High/Low registers and replacing the separate Mult and Div blocks. It performs signed/unsigned multiply (shift-add) and signed/unsigned divide (restoring, on magnitudes) over a configurable operand width. It uses a Start/Busy/Done handshake with the control unit and flags divide-by-zero.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Start/Busy/Done bundle between the control unit
// and the multicycle multiply/divide unit.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic             DivZero;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output Start, Op, A, B,
      input  Busy, Done, DivZero, Hi, Lo
   );

   modport slave (
      input  Start, Op, A, B,
      output Busy, Done, DivZero, Hi, Lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle shift-add multiplier and restoring divider
// working on magnitudes, with a final sign-fix cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic              Clk,
   input logic              Reset,
   mult_div_unit_if.slave   bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } stateT;

   stateT              state;
   logic [CW-1:0]      count;
   logic               isDiv;
   logic               isSigned;
   logic               negA;
   logic               negB;
   logic               zeroPend;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   opX;
   logic [WIDTH-1:0]   opY;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic               busyReg;
   logic               doneReg;
   logic               divZeroReg;

   logic               inSigned;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNext;
   logic [WIDTH:0]     divShift;
   logic [WIDTH+1:0]   divDiff;
   logic               divNeg;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   remOut;

   assign bus.Busy    = busyReg;
   assign bus.Done    = doneReg;
   assign bus.DivZero = divZeroReg;
   assign bus.Hi      = hiReg;
   assign bus.Lo      = loReg;

   // Operand magnitudes, one iteration of each algorithm, and sign fix.
   always_comb begin
      inSigned = ~bus.Op[0];
      magA     = bus.A;
      magB     = bus.B;
      if (inSigned && bus.A[WIDTH-1]) magA = -bus.A;
      if (inSigned && bus.B[WIDTH-1]) magB = -bus.B;

      mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + {1'b0, (opX[0] ? opY : '0)};
      mulNext = {mulSum, acc[WIDTH-1:1]};

      divShift = {rem[WIDTH-1:0], opX[WIDTH-1]};
      divDiff  = {1'b0, divShift} - {2'b00, opY};
      divNeg   = divDiff[WIDTH+1];

      prod   = acc;
      quo    = opX;
      remOut = rem[WIDTH-1:0];
      if (isSigned && (negA ^ negB)) begin
         prod = -acc;
         quo  = -opX;
      end
      if (isSigned && negA) remOut = -rem[WIDTH-1:0];
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         count      <= '0;
         isDiv      <= 1'b0;
         isSigned   <= 1'b0;
         negA       <= 1'b0;
         negB       <= 1'b0;
         zeroPend   <= 1'b0;
         acc        <= '0;
         rem        <= '0;
         opX        <= '0;
         opY        <= '0;
         hiReg      <= '0;
         loReg      <= '0;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
         divZeroReg <= 1'b0;
      end else begin
         doneReg    <= 1'b0;
         divZeroReg <= 1'b0;
         unique case (state)
            IDLE: begin
               if (zeroPend) begin
                  doneReg    <= 1'b1;
                  divZeroReg <= 1'b1;
                  zeroPend   <= 1'b0;
               end
               if (bus.Start) begin
                  if (bus.Op[1] && (bus.B == '0)) begin
                     zeroPend <= 1'b1;
                  end else begin
                     state    <= RUN;
                     busyReg  <= 1'b1;
                     count    <= '0;
                     isDiv    <= bus.Op[1];
                     isSigned <= inSigned;
                     negA     <= inSigned & bus.A[WIDTH-1];
                     negB     <= inSigned & bus.B[WIDTH-1];
                     acc      <= '0;
                     rem      <= '0;
                     // opX shifts (multiplier / dividend->quotient),
                     // opY stays put (multiplicand / divisor).
                     opX      <= bus.Op[1] ? magA : magB;
                     opY      <= bus.Op[1] ? magB : magA;
                  end
               end
            end
            RUN: begin
               count <= count + 1'b1;
               if (isDiv) begin
                  rem <= divNeg ? divShift : divDiff[WIDTH:0];
                  opX <= {opX[WIDTH-2:0], ~divNeg};
               end else begin
                  acc <= mulNext;
                  opX <= opX >> 1;
               end
               if (count == LAST) state <= FIX;
            end
            FIX: begin
               if (isDiv) begin
                  hiReg <= remOut;
                  loReg <= quo;
               end else begin
                  hiReg <= prod[2*WIDTH-1:WIDTH];
                  loReg <= prod[WIDTH-1:0];
               end
               doneReg <= 1'b1;
               busyReg <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH 32 and 8:
// results, handshake timing, divide-by-zero, reset abort.
module tb_mult_div_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failed = 0;
   logic bad;

   mult_div_unit_if #(.WIDTH(32)) bus32 ();
   mult_div_unit_if #(.WIDTH(8))  bus8 ();

   mult_div_unit #(.WIDTH(32)) dut32 (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus32)
   );

   mult_div_unit #(.WIDTH(8)) dut8 (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus8)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run32(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eHi, input logic [31:0] eLo);
      bus32.Start = 1'b1;
      bus32.Op    = op;
      bus32.A     = a;
      bus32.B     = b;
      tick();
      bus32.Start = 1'b0;
      bus32.A     = 32'hDEADBEEF;
      bus32.B     = 32'h0BADF00D;
      bus32.Op    = ~op;
      check({tag, "_busyK"}, 64'(bus32.Busy), 64'd1);
      check({tag, "_doneK"}, 64'(bus32.Done), 64'd0);
      bad = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (bus32.Busy !== 1'b1 || bus32.Done !== 1'b0) bad = 1'b1;
      end
      check({tag, "_run"}, 64'(bad), 64'd0);
      tick();
      check({tag, "_done"}, 64'(bus32.Done), 64'd1);
      check({tag, "_busy"}, 64'(bus32.Busy), 64'd0);
      check({tag, "_dz"}, 64'(bus32.DivZero), 64'd0);
      check({tag, "_hi"}, 64'(bus32.Hi), 64'(eHi));
      check({tag, "_lo"}, 64'(bus32.Lo), 64'(eLo));
   endtask

   task automatic run8(input string tag, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eHi, input logic [7:0] eLo);
      bus8.Start = 1'b1;
      bus8.Op    = op;
      bus8.A     = a;
      bus8.B     = b;
      tick();
      bus8.Start = 1'b0;
      bus8.A     = 8'h5A;
      bus8.B     = 8'hA5;
      check({tag, "_busyK"}, 64'(bus8.Busy), 64'd1);
      bad = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (bus8.Busy !== 1'b1 || bus8.Done !== 1'b0) bad = 1'b1;
      end
      check({tag, "_run"}, 64'(bad), 64'd0);
      tick();
      check({tag, "_done"}, 64'(bus8.Done), 64'd1);
      check({tag, "_busy"}, 64'(bus8.Busy), 64'd0);
      check({tag, "_hi"}, 64'(bus8.Hi), 64'(eHi));
      check({tag, "_lo"}, 64'(bus8.Lo), 64'(eLo));
   endtask

   // Directed sequence.
   initial begin
      bus32.Start = 1'b0;
      bus32.Op    = 2'b00;
      bus32.A     = '0;
      bus32.B     = '0;
      bus8.Start  = 1'b0;
      bus8.Op     = 2'b00;
      bus8.A      = '0;
      bus8.B      = '0;
      tick();
      tick();
      check("rst_busy", 64'(bus32.Busy), 64'd0);
      check("rst_done", 64'(bus32.Done), 64'd0);
      check("rst_dz", 64'(bus32.DivZero), 64'd0);
      check("rst_hi", 64'(bus32.Hi), 64'd0);
      check("rst_lo", 64'(bus32.Lo), 64'd0);
      check("rst8_hilo", {bus8.Hi, bus8.Lo}, 64'd0);
      rst = 1'b0;
      tick();

      run32("mult", 2'b00, 32'hFFFFFFFD, 32'd5,
            32'hFFFFFFFF, 32'hFFFFFFF1);
      run32("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001);
      run32("divu", 2'b11, 32'd100, 32'd7,
            32'h00000002, 32'h0000000E);
      run32("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD);
      run32("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
            32'h00000000, 32'h80000000);
      run32("divu_pre", 2'b11, 32'h00003412, 32'h00000100,
            32'h00000012, 32'h00000034);

      bus32.Start = 1'b1;
      bus32.Op    = 2'b10;
      bus32.A     = 32'd5;
      bus32.B     = 32'd0;
      tick();
      bus32.Start = 1'b0;
      check("dz_k_done", 64'(bus32.Done), 64'd0);
      check("dz_k_busy", 64'(bus32.Busy), 64'd0);
      tick();
      check("dz_done", 64'(bus32.Done), 64'd1);
      check("dz_flag", 64'(bus32.DivZero), 64'd1);
      check("dz_busy", 64'(bus32.Busy), 64'd0);
      check("dz_hi", 64'(bus32.Hi), 64'h12);
      check("dz_lo", 64'(bus32.Lo), 64'h34);
      tick();
      check("dz_pulse", {62'd0, bus32.Done, bus32.DivZero}, 64'd0);
      check("dz_hold", {bus32.Hi, bus32.Lo}, 64'h00000012_00000034);

      bus32.Start = 1'b1;
      bus32.Op    = 2'b01;
      bus32.A     = 32'd6;
      bus32.B     = 32'd7;
      tick();
      bus32.Start = 1'b0;
      bad = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         if (i >= 4 && i <= 6) begin
            bus32.Start = 1'b1;
            bus32.Op    = 2'b11;
            bus32.A     = 32'd1000;
            bus32.B     = 32'd3;
         end else begin
            bus32.Start = 1'b0;
         end
         tick();
         if (bus32.Busy !== 1'b1 || bus32.Done !== 1'b0) bad = 1'b1;
      end
      check("ign_run", 64'(bad), 64'd0);
      tick();
      check("ign_done", 64'(bus32.Done), 64'd1);
      check("ign_result", {bus32.Hi, bus32.Lo}, 64'd42);
      tick();
      check("ign_idle", 64'(bus32.Busy), 64'd0);

      bus32.Start = 1'b1;
      bus32.Op    = 2'b00;
      bus32.A     = 32'd3;
      bus32.B     = 32'd4;
      tick();
      bus32.Start = 1'b0;
      for (int i = 1; i <= 9; i++) tick();
      rst = 1'b1;
      tick();
      check("abort_busy", 64'(bus32.Busy), 64'd0);
      check("abort_hilo", {bus32.Hi, bus32.Lo}, 64'd0);
      check("abort_done", 64'(bus32.Done), 64'd0);
      rst = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus32.Done !== 1'b0 || bus32.Busy !== 1'b0) bad = 1'b1;
      end
      check("abort_quiet", 64'(bad), 64'd0);

      run8("mult8", 2'b00, 8'h80, 8'h80, 8'h40, 8'h00);
      run8("divu8", 2'b11, 8'd200, 8'd7, 8'd4, 8'd28);
      run8("div8_ovf", 2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
